// File: rtl/traffic_pkg.sv
// Shared encodings for the three-way traffic light controller and its monitor.
// Bus patterns are packed as {M1, M2, MT, S}, each {R,Y,G} one-hot.
package traffic_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    localparam logic [2:0] PH_NONE = 3'd0;
    localparam logic [2:0] PH_S1   = 3'd1;
    localparam logic [2:0] PH_S2   = 3'd2;
    localparam logic [2:0] PH_S3   = 3'd3;
    localparam logic [2:0] PH_S4   = 3'd4;
    localparam logic [2:0] PH_S5   = 3'd5;
    localparam logic [2:0] PH_S6   = 3'd6;

    localparam logic [11:0] PAT_S1 = {LT_GRN, LT_GRN, LT_RED, LT_RED};
    localparam logic [11:0] PAT_S2 = {LT_GRN, LT_YEL, LT_RED, LT_RED};
    localparam logic [11:0] PAT_S3 = {LT_GRN, LT_RED, LT_GRN, LT_RED};
    localparam logic [11:0] PAT_S4 = {LT_YEL, LT_RED, LT_YEL, LT_RED};
    localparam logic [11:0] PAT_S5 = {LT_RED, LT_RED, LT_RED, LT_GRN};
    localparam logic [11:0] PAT_S6 = {LT_RED, LT_RED, LT_RED, LT_YEL};

    typedef struct packed {
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] mt;
        logic [2:0] s;
    } light_bus_t;

    // Legal phase order wraps S6 back to S1.
    function automatic logic [2:0] next_phase(input logic [2:0] ph);
        next_phase = (ph == PH_S6) ? PH_S1 : ph + 3'd1;
    endfunction

endpackage

// File: rtl/traffic_phase_decode.sv
// Maps a sampled 12-bit light pattern to its phase code; anything outside
// the six reference patterns is reported as not legal.
module traffic_phase_decode
    import traffic_pkg::*;
(
    input  logic [11:0] pattern,
    output logic [2:0]  phase,
    output logic        legal
);

    always_comb begin
        phase = PH_NONE;
        legal = 1'b1;
        case (pattern)
            PAT_S1:  phase = PH_S1;
            PAT_S2:  phase = PH_S2;
            PAT_S3:  phase = PH_S3;
            PAT_S4:  phase = PH_S4;
            PAT_S5:  phase = PH_S5;
            PAT_S6:  phase = PH_S6;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive observer of the controller's light buses: tracks phase order and
// durations, raises sticky error flags, and counts completed laps.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int T_S1 = 7,
    parameter int T_S2 = 2,
    parameter int T_S3 = 5,
    parameter int T_S4 = 2,
    parameter int T_S5 = 3,
    parameter int T_S6 = 2,
    parameter int DW   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    output logic [2:0] phase,
    output logic       locked,
    output logic       err_illegal,
    output logic       err_seq,
    output logic       err_time,
    output logic [7:0] cycle_count
);

    light_bus_t    bus;
    logic [2:0]    dec_phase;
    logic          dec_legal;
    logic [2:0]    prev_phase;
    logic [DW-1:0] dur_cnt;
    logic          first;
    logic          in_order;
    logic          dur_ok;

    assign bus = '{m1: light_M1, m2: light_M2, mt: light_MT, s: light_S};

    traffic_phase_decode u_decode (
        .pattern (bus),
        .phase   (dec_phase),
        .legal   (dec_legal)
    );

    function automatic logic [DW-1:0] t_of(input logic [2:0] ph);
        case (ph)
            PH_S1:   t_of = DW'(T_S1);
            PH_S2:   t_of = DW'(T_S2);
            PH_S3:   t_of = DW'(T_S3);
            PH_S4:   t_of = DW'(T_S4);
            PH_S5:   t_of = DW'(T_S5);
            PH_S6:   t_of = DW'(T_S6);
            default: t_of = '0;
        endcase
    endfunction

    assign in_order = (dec_phase == next_phase(phase));
    assign dur_ok   = (dur_cnt == t_of(phase));

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase       <= PH_NONE;
            prev_phase  <= PH_NONE;
            locked      <= 1'b0;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_time    <= 1'b0;
            cycle_count <= 8'd0;
            dur_cnt     <= '0;
            first       <= 1'b1;
        end else if (!dec_legal) begin
            err_illegal <= 1'b1;
            locked      <= 1'b0;
            phase       <= PH_NONE;
            dur_cnt     <= '0;
            first       <= 1'b1;
        end else if (!locked) begin
            // The phase we land in may be partial, so its length is not checked.
            locked  <= 1'b1;
            phase   <= dec_phase;
            dur_cnt <= DW'(1);
            first   <= 1'b1;
        end else if (dec_phase == phase) begin
            if (dur_cnt != '1)
                dur_cnt <= dur_cnt + DW'(1);
        end else begin
            if (!in_order)
                err_seq <= 1'b1;
            if (!first && !dur_ok)
                err_time <= 1'b1;
            if (in_order && phase == PH_S6)
                cycle_count <= cycle_count + 8'd1;
            prev_phase <= phase;
            phase      <= dec_phase;
            dur_cnt    <= DW'(1);
            first      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench: fixed vector table, directed corner sequences and
// randomized traffic compared against a run-length based reference model.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
    localparam int TDUR [7] = '{0, 7, 2, 5, 2, 3, 2};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] light_M1 = R, light_M2 = R, light_MT = R, light_S = R;
    logic [2:0] phase;
    logic       locked, err_illegal, err_seq, err_time;
    logic [7:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    traffic_light_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .light_M1    (light_M1),
        .light_M2    (light_M2),
        .light_MT    (light_MT),
        .light_S     (light_S),
        .phase       (phase),
        .locked      (locked),
        .err_illegal (err_illegal),
        .err_seq     (err_seq),
        .err_time    (err_time),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    logic [11:0] pats [7];

    // Reference model: remembers when the current run began and judges a run
    // by its length once a different phase shows up.
    int  cyc = 0;
    int  m_phase = 0, m_start = 0, m_laps = 0;
    bit  m_locked = 0, m_exempt = 1, m_ill = 0, m_seq = 0, m_time = 0;

    function automatic int decode_ref(input logic [11:0] p);
        decode_ref = 0;
        for (int k = 1; k <= 6; k++)
            if (pats[k] == p) decode_ref = k;
    endfunction

    task automatic model_step(input logic [11:0] p, input bit rst_n);
        int d;
        d = decode_ref(p);
        cyc++;
        if (!rst_n) begin
            m_phase = 0; m_locked = 0; m_ill = 0; m_seq = 0; m_time = 0;
            m_laps = 0; m_exempt = 1;
        end else if (d == 0) begin
            m_ill = 1; m_locked = 0; m_phase = 0;
        end else if (!m_locked || d != m_phase) begin
            if (m_locked) begin
                if (d != (m_phase % 6) + 1) m_seq = 1;
                if (!m_exempt && (cyc - m_start) != TDUR[m_phase]) m_time = 1;
                if (m_phase == 6 && d == 1) m_laps = (m_laps + 1) % 256;
                m_exempt = 0;
            end else begin
                m_exempt = 1;
            end
            m_locked = 1; m_phase = d; m_start = cyc;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        outs = {phase, locked, err_illegal, err_seq, err_time, cycle_count, 1'b0};
    endfunction

    function automatic logic [16:0] model_outs();
        model_outs = {3'(m_phase), m_locked, m_ill, m_seq, m_time, 8'(m_laps), 1'b0};
    endfunction

    task automatic step(input logic [11:0] p, input bit rst_n);
        {light_M1, light_M2, light_MT, light_S} = p;
        reset = rst_n;
        @(posedge clk);
        #1;
        model_step(p, rst_n);
    endtask

    task automatic hold(input int ph, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            step(pats[ph], 1'b1);
            check(name, 32'(outs()), 32'(model_outs()));
        end
    endtask

    task automatic lap(input string name);
        for (int ph = 1; ph <= 6; ph++) hold(ph, TDUR[ph], name);
    endtask

    typedef struct {
        logic [11:0] pat;
        bit          rst_n;
        logic [2:0]  e_phase;
        logic        e_locked;
        logic [2:0]  e_err;   // {illegal, seq, time}
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs [14];

    initial begin
        pats[0] = 12'h000;
        pats[1] = {G, G, R, R};
        pats[2] = {G, Y, R, R};
        pats[3] = {G, R, G, R};
        pats[4] = {Y, R, Y, R};
        pats[5] = {R, R, R, G};
        pats[6] = {R, R, R, Y};

        vecs[0]  = '{12'hFFF,           0, 3'd0, 0, 3'b000, 8'd0};
        vecs[1]  = '{pats[4],           1, 3'd4, 1, 3'b000, 8'd0};
        vecs[2]  = '{pats[5],           1, 3'd5, 1, 3'b000, 8'd0};
        vecs[3]  = '{pats[5],           1, 3'd5, 1, 3'b000, 8'd0};
        vecs[4]  = '{pats[5],           1, 3'd5, 1, 3'b000, 8'd0};
        vecs[5]  = '{pats[6],           1, 3'd6, 1, 3'b000, 8'd0};
        vecs[6]  = '{pats[6],           1, 3'd6, 1, 3'b000, 8'd0};
        vecs[7]  = '{pats[1],           1, 3'd1, 1, 3'b000, 8'd1};
        vecs[8]  = '{pats[3],           1, 3'd3, 1, 3'b011, 8'd1};
        vecs[9]  = '{{3'b011, R, G, R}, 1, 3'd0, 0, 3'b111, 8'd1};
        vecs[10] = '{pats[3],           1, 3'd3, 1, 3'b111, 8'd1};
        vecs[11] = '{pats[3],           0, 3'd0, 0, 3'b000, 8'd0};
        vecs[12] = '{pats[3],           1, 3'd3, 1, 3'b000, 8'd0};
        vecs[13] = '{pats[4],           1, 3'd4, 1, 3'b000, 8'd0};

        // Vector table: mid-lap entry, wrong transition, illegal pulse, reset.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].pat, vecs[i].rst_n);
            check($sformatf("vec%0d", i),
                  {phase, locked, err_illegal, err_seq, err_time, cycle_count},
                  {vecs[i].e_phase, vecs[i].e_locked, vecs[i].e_err, vecs[i].e_cnt});
        end

        // Three clean laps.
        step(pats[1], 1'b0);
        check("reset_state", 32'(outs()), 32'd0);
        for (int l = 0; l < 3; l++) lap("legal_lap");
        hold(1, 1, "legal_close");
        check("legal_count", 32'(cycle_count), 32'd3);
        check("legal_errs", {err_illegal, err_seq, err_time}, 3'b000);

        // Short S1 then a skipped S3.
        step(pats[1], 1'b0);
        hold(6, 2, "short_pre");
        hold(1, 6, "short_s1");
        hold(2, 1, "short_s2");
        check("short_time", 32'({err_time, err_seq}), 32'b10);
        hold(2, 1, "skip_s2");
        hold(4, 1, "skip_s4");
        check("skip_seq", 32'({err_seq, phase}), 32'({1'b1, 3'd4}));
        hold(4, 1, "skip_cont");
        hold(5, 3, "skip_cont");
        hold(6, 2, "skip_cont");
        hold(1, 1, "skip_cont");

        // Lap counter wrap.
        step(pats[1], 1'b0);
        for (int l = 0; l < 256; l++) lap("wrap_lap");
        check("wrap_255", 32'(cycle_count), 32'd255);
        hold(1, 1, "wrap_close");
        check("wrap_zero", 32'({cycle_count, err_illegal, err_seq, err_time}), 32'd0);

        // Randomized traffic: mostly legal, with timing slips, skips, junk, resets.
        begin
            int cur = 1;
            int r, n, nxt;
            step(pats[1], 1'b0);
            for (int s = 0; s < 600; s++) begin
                r = $urandom_range(0, 99);
                if (r < 65) begin
                    nxt = (cur % 6) + 1; n = TDUR[nxt];
                end else if (r < 78) begin
                    nxt = (cur % 6) + 1;
                    n = TDUR[nxt] + (($urandom_range(0, 1) == 1) ? 1 : -1);
                end else if (r < 88) begin
                    nxt = $urandom_range(1, 6); n = $urandom_range(1, 8);
                end else if (r < 96) begin
                    nxt = 0; n = $urandom_range(1, 2);
                end else begin
                    nxt = -1; n = 1;
                end
                for (int k = 0; k < n; k++) begin
                    if (nxt == -1) step(12'($urandom), 1'b0);
                    else if (nxt == 0) step(12'($urandom), 1'b1);
                    else step(pats[nxt], 1'b1);
                    check("random", 32'(outs()), 32'(model_outs()));
                end
                if (nxt > 0) cur = nxt;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
